wbuart_tx: RTL

WBUART_TX -- requirements
Module: wbuart_tx

---
 rtl/wbuart_tx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/wbuart_tx.sv
// Wishbone-attached transmit-only UART with a small TX FIFO.
// Register map: DATA, STATUS, DIVISOR, CTRL on word address [1:0].
module wbuart_tx #(
  parameter int          AW         = 30,
  parameter int          DW         = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_ack_o,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            tx_o,
  output logic            irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;
  logic          pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty, busy;

  logic [15:0]   divisor;
  logic          irq_en;
  logic          ovf;

  logic          req, wr;
  logic [1:0]    adr;
  logic          push_req, push_ok, ovf_set;
  logic [DW-1:0] rd_val;
  logic [31:0]   lvl_w;
  logic [3:0]    lvl_field;
  logic          unused_bits;

  assign unused_bits = ^{wb_adr_i[AW-1:2],
                         wb_dat_i[DW-1:16],
                         wb_sel_i[DW/8-1:2]};

  // Side effects happen only on the edge that raises ack.
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr  = req & wb_we_i;
  assign adr = wb_adr_i[1:0];

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign busy  = (state != S_IDLE);

  assign push_req = wr & (adr == 2'd0) & wb_sel_i[0];
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  assign lvl_w     = 32'(level);
  assign lvl_field = (lvl_w > 32'd15) ? 4'hf : lvl_w[3:0];

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= wb_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx_o    <= tx_n;
    end
  end

  // Each state holds for DIVISOR+1 clocks; cnt reloads at every bit start.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx_o;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          state_n = S_START;
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          cnt_n   = divisor;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (cnt == 16'd0) begin
          state_n   = S_DATA;
          cnt_n     = divisor;
          bit_idx_n = 3'd0;
          tx_n      = shreg[0];
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == 16'd0) begin
          cnt_n = divisor;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt == 16'd0) begin
          if (!empty) begin
            state_n = S_START;
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            cnt_n   = divisor;
            tx_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    unique case (adr)
      2'd1: begin
        rd_val[0]    = full;
        rd_val[1]    = empty;
        rd_val[2]    = busy;
        rd_val[3]    = ovf;
        rd_val[11:8] = lvl_field;
      end
      2'd2:    rd_val[15:0] = divisor;
      2'd3:    rd_val[0]    = irq_en;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      divisor  <= DIV_RESET;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= req;
      irq_o    <= irq_en & empty & ~busy;
      if (req) wb_dat_o <= wb_we_i ? '0 : rd_val;
      if (ovf_set) ovf <= 1'b1;
      if (wr && adr == 2'd1 && wb_sel_i[0] && wb_dat_i[3])
        ovf <= 1'b0;
      if (wr && adr == 2'd2) begin
        if (wb_sel_i[0]) divisor[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) divisor[15:8] <= wb_dat_i[15:8];
      end
      if (wr && adr == 2'd3 && wb_sel_i[0])
        irq_en <= wb_dat_i[0];
    end
  end

endmodule
